// File: rtl/axil_reg_bank_if.sv
// axil_reg_bank_if: AXI4-Lite bus bundle between a master and axil_reg_bank
interface axil_reg_bank_if #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 8
);
   logic [C_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                AWPROT;
   logic                      AWVALID;
   logic                      AWREADY;
   logic [C_DATA_WIDTH-1:0]   WDATA;
   logic [C_DATA_WIDTH/8-1:0] WSTRB;
   logic                      WVALID;
   logic                      WREADY;
   logic [1:0]                BRESP;
   logic                      BVALID;
   logic                      BREADY;
   logic [C_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                ARPROT;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [C_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                RRESP;
   logic                      RVALID;
   logic                      RREADY;
   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite register bank with byte-strobed writes and read-only status registers
module axil_reg_bank #(
   parameter int                    C_DATA_WIDTH = 32,
   parameter int                    C_NUM_REGS   = 8,
   parameter int                    C_ADDR_WIDTH = 8,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   axil_reg_bank_if.slave                     s_axi,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
   input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
   output logic [C_NUM_REGS-1:0]              wr_pulse
);
   localparam int NB  = C_DATA_WIDTH / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = C_ADDR_WIDTH - LSB;
   localparam int RW  = $clog2(C_NUM_REGS);
   typedef enum logic [1:0] {IDLE, COMMIT, RESP} wstate_t;
   wstate_t                 state_q, state_d;
   logic                    aw_held_q, w_held_q, rvalid_q;
   logic [C_ADDR_WIDTH-1:0] aw_addr_q;
   logic [C_DATA_WIDTH-1:0] w_data_q, rdata_q;
   logic [NB-1:0]           w_strb_q;
   logic [1:0]              bresp_q, rresp_q;
   logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
   logic [C_DATA_WIDTH-1:0] status [C_NUM_REGS];
   logic                    aw_hs, w_hs, ar_hs, wr_ok, rd_in;
   logic [IW-1:0]           wr_idx, rd_idx;
   logic [RW-1:0]           wr_sel, rd_sel;
   logic                    unused_bits;
   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_map
      assign reg_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[g];
      assign status[g] = status_in[g*C_DATA_WIDTH +: C_DATA_WIDTH];
   end
   assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, aw_addr_q[LSB-1:0], s_axi.ARADDR[LSB-1:0]};
   assign wr_idx = aw_addr_q[C_ADDR_WIDTH-1:LSB];
   assign rd_idx = s_axi.ARADDR[C_ADDR_WIDTH-1:LSB];
   assign wr_sel = wr_idx[RW-1:0];
   assign rd_sel = rd_idx[RW-1:0];
   assign wr_ok  = (32'(wr_idx) < 32'(C_NUM_REGS)) && !C_RO_MASK[wr_sel];
   assign rd_in  = 32'(rd_idx) < 32'(C_NUM_REGS);
   assign s_axi.AWREADY = !ARESET && !aw_held_q && state_q != RESP;
   assign s_axi.WREADY  = !ARESET && !w_held_q && state_q != RESP;
   assign s_axi.ARREADY = !ARESET && !rvalid_q;
   assign s_axi.BVALID  = state_q == RESP;
   assign s_axi.BRESP   = bresp_q;
   assign s_axi.RVALID  = rvalid_q;
   assign s_axi.RDATA   = rdata_q;
   assign s_axi.RRESP   = rresp_q;
   assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
   assign w_hs  = s_axi.WVALID && s_axi.WREADY;
   assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;
   assign wr_pulse = (state_q == COMMIT && wr_ok && !ARESET) ? C_NUM_REGS'(1) << wr_sel : '0;
   // Commit as soon as both halves are present, including when they arrive on this very edge
   always_comb begin
      state_d = state_q == IDLE   ? (((aw_held_q || aw_hs) && (w_held_q || w_hs)) ? COMMIT : IDLE) :
                state_q == COMMIT ? RESP :
                                    (s_axi.BREADY ? IDLE : RESP);
   end
   // Write FSM state and the response code captured at commit
   always_ff @(posedge ACLK) begin
      state_q <= ARESET ? IDLE : state_d;
      if (ARESET) bresp_q <= 2'b00;
      else if (state_q == COMMIT) bresp_q <= wr_ok ? 2'b00 : 2'b10;
   end
   // Independent AW and W holding registers, released once the commit has used them
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= s_axi.AWADDR;
         end else if (state_q == COMMIT) aw_held_q <= 1'b0;
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi.WDATA;
            w_strb_q <= s_axi.WSTRB;
         end else if (state_q == COMMIT) w_held_q <= 1'b0;
      end
   end
   // Byte-lane merge into the addressed writable register
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
      end else if (state_q == COMMIT && wr_ok) begin
         for (int b = 0; b < NB; b++)
            if (w_strb_q[b]) regs_q[wr_sel][8*b +: 8] <= w_data_q[8*b +: 8];
      end
   end
   // Read channel: capture data at the AR handshake, hold until accepted
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= 2'b00;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= !rd_in ? '0 : C_RO_MASK[rd_sel] ? status[rd_sel] : regs_q[rd_sel];
         rresp_q  <= rd_in ? 2'b00 : 2'b10;
      end else if (s_axi.RREADY) rvalid_q <= 1'b0;
   end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: two register banks (one with reg1 read-only, one all-writable) driven in lockstep against an array model
module tb_axil_reg_bank;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 8;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR*DW-1:0] status_in = '0;
   logic [NR*DW-1:0] reg_out0, reg_out1;
   logic [NR-1:0]    wr_pulse0, wr_pulse1;
   logic [DW-1:0]    mdl [2][NR];
   logic [NR-1:0]    ro [2];
   int               pcnt [2][NR];
   int               cyc = 0;
   int               tests = 0;
   int               fails = 0;
   logic [DW-1:0]    got;
   logic             bv [2];
   logic             rv [2];
   logic [1:0]       br [2];
   logic [1:0]       rr [2];
   logic [DW-1:0]    rdat [2];

   always #5 clk = ~clk;

   axil_reg_bank_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) bus0 ();
   axil_reg_bank_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) bus1 ();
   assign bus1.AWADDR  = bus0.AWADDR;
   assign bus1.AWPROT  = bus0.AWPROT;
   assign bus1.AWVALID = bus0.AWVALID;
   assign bus1.WDATA   = bus0.WDATA;
   assign bus1.WSTRB   = bus0.WSTRB;
   assign bus1.WVALID  = bus0.WVALID;
   assign bus1.BREADY  = bus0.BREADY;
   assign bus1.ARADDR  = bus0.ARADDR;
   assign bus1.ARPROT  = bus0.ARPROT;
   assign bus1.ARVALID = bus0.ARVALID;
   assign bus1.RREADY  = bus0.RREADY;
   assign bv[0] = bus0.BVALID;
   assign bv[1] = bus1.BVALID;
   assign rv[0] = bus0.RVALID;
   assign rv[1] = bus1.RVALID;
   assign br[0] = bus0.BRESP;
   assign br[1] = bus1.BRESP;
   assign rr[0] = bus0.RRESP;
   assign rr[1] = bus1.RRESP;
   assign rdat[0] = bus0.RDATA;
   assign rdat[1] = bus1.RDATA;

   axil_reg_bank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW), .C_RO_MASK(8'h02)) dut0 (
      .ACLK(clk), .ARESET(rst), .s_axi(bus0), .reg_out(reg_out0), .status_in(status_in), .wr_pulse(wr_pulse0));
   axil_reg_bank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW), .C_RO_MASK(8'h00)) dut1 (
      .ACLK(clk), .ARESET(rst), .s_axi(bus1), .reg_out(reg_out1), .status_in(status_in), .wr_pulse(wr_pulse1));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      for (int i = 0; i < NR; i++) begin
         pcnt[0][i] += int'(wr_pulse0[i]);
         pcnt[1][i] += int'(wr_pulse1[i]);
      end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_regs();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++)
            check("reg_out", d == 0 ? reg_out0[i*DW +: DW] : reg_out1[i*DW +: DW], mdl[d][i]);
   endtask

   // Called and returns one time unit after a rising edge
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                     input int daw, input int dw, input int db);
      int p0 [2][NR];
      int ca, cw, na, nw, n, idx, tot;
      logic ra, rw, ok;
      logic [1:0] er [2];
      p0 = pcnt;
      ca = 0;
      cw = 0;
      fork
         begin
            repeat (daw) begin @(posedge clk); #1; end
            bus0.AWADDR = a;
            bus0.AWVALID = 1'b1;
            na = 0;
            do begin @(negedge clk); ra = bus0.AWREADY; @(posedge clk); #1; na++; end while (!ra && na < 50);
            bus0.AWVALID = 1'b0;
            ca = cyc;
            check("aw_handshake", ra, 1);
         end
         begin
            repeat (dw) begin @(posedge clk); #1; end
            bus0.WDATA = data;
            bus0.WSTRB = strb;
            bus0.WVALID = 1'b1;
            nw = 0;
            do begin @(negedge clk); rw = bus0.WREADY; @(posedge clk); #1; nw++; end while (!rw && nw < 50);
            bus0.WVALID = 1'b0;
            cw = cyc;
            check("w_handshake", rw, 1);
         end
      join
      n = 0;
      do begin @(negedge clk); n++; end while (!bv[0] && n < 50);
      check("bvalid", bv[0], 1);
      check("wr_latency", cyc, (ca > cw ? ca : cw) + 1);
      idx = int'(a) >> 2;
      for (int d = 0; d < 2; d++) begin
         ok = (idx < NR) ? !ro[d][idx] : 1'b0;
         er[d] = ok ? 2'b00 : 2'b10;
         check("bresp", br[d], er[d]);
      end
      for (int i = 0; i < db; i++) begin
         @(negedge clk);
         check("bvalid_hold", bv[0], 1);
         for (int d = 0; d < 2; d++) check("bresp_hold", br[d], er[d]);
      end
      bus0.BREADY = 1'b1;
      @(posedge clk);
      #1;
      bus0.BREADY = 1'b0;
      check("bvalid_drop", bv[0], 0);
      for (int d = 0; d < 2; d++) begin
         ok = (idx < NR) ? !ro[d][idx] : 1'b0;
         tot = 0;
         for (int i = 0; i < NR; i++) tot += pcnt[d][i] - p0[d][i];
         check("wr_pulse_count", tot, ok);
         if (ok) begin
            check("wr_pulse_reg", pcnt[d][idx] - p0[d][idx], 1);
            for (int b = 0; b < DW/8; b++) if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
         end
      end
      check_regs();
   endtask

   // Called and returns one time unit after a rising edge; returns what dut0 presented
   task automatic rd(input logic [AW-1:0] a, input int dar, input int dr, output logic [DW-1:0] got0);
      logic [DW-1:0] ed [2];
      logic [1:0] er [2];
      int idx, n;
      logic r;
      repeat (dar) begin @(posedge clk); #1; end
      bus0.ARADDR = a;
      bus0.ARVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); r = bus0.ARREADY; @(posedge clk); #1; n++; end while (!r && n < 50);
      bus0.ARVALID = 1'b0;
      check("ar_handshake", r, 1);
      idx = int'(a) >> 2;
      for (int d = 0; d < 2; d++) begin
         ed[d] = idx >= NR ? '0 : ro[d][idx] ? status_in[idx*DW +: DW] : mdl[d][idx];
         er[d] = idx >= NR ? 2'b10 : 2'b00;
      end
      @(negedge clk);
      got0 = rdat[0];
      for (int d = 0; d < 2; d++) begin
         check("rvalid", rv[d], 1);
         check("rdata", rdat[d], ed[d]);
         check("rresp", rr[d], er[d]);
      end
      for (int i = 0; i < dr; i++) begin
         @(negedge clk);
         check("rvalid_hold", rv[0], 1);
         check("rdata_hold", rdat[0], ed[0]);
      end
      bus0.RREADY = 1'b1;
      @(posedge clk);
      #1;
      bus0.RREADY = 1'b0;
      check("rvalid_drop", rv[0], 0);
   endtask

   initial begin
      ro[0] = 8'h02;
      ro[1] = 8'h00;
      for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) begin mdl[d][i] = '0; pcnt[d][i] = 0; end
      bus0.AWADDR = '0; bus0.AWPROT = '0; bus0.AWVALID = 1'b0;
      bus0.WDATA = '0; bus0.WSTRB = '0; bus0.WVALID = 1'b0; bus0.BREADY = 1'b0;
      bus0.ARADDR = '0; bus0.ARPROT = '0; bus0.ARVALID = 1'b0; bus0.RREADY = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", bus0.AWREADY, 0);
      check("rst_wready", bus0.WREADY, 0);
      check("rst_arready", bus0.ARREADY, 0);
      check("rst_bvalid", bv[0], 0);
      check("rst_rvalid", rv[0], 0);
      check("rst_bresp", br[0], 0);
      check("rst_rresp", rr[0], 0);
      check("rst_rdata", rdat[0], 0);
      check("rst_wr_pulse", {wr_pulse1, wr_pulse0}, 0);
      check_regs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("awready_up", bus0.AWREADY, 1);
      check("wready_up", bus0.WREADY, 1);
      check("arready_up", bus0.ARREADY, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) wr(AW'(4*i), DW'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) rd(AW'(4*i), 0, 0, got);
      wr(8'h00, 32'hAABBCCDD, 4'hF, 1, 0, 0);
      wr(8'h00, 32'h11223344, 4'b0101, 0, 2, 1);
      rd(8'h00, 0, 1, got);
      check("strobe_merge", got, 32'hAA22CC44);
      wr(8'h00, 32'h5A5A0030, 4'hF, 3, 0, 5);
      status_in[DW +: DW] = 32'hDEAD0001;
      wr(8'h04, 32'h5, 4'hF, 0, 0, 0);
      rd(8'h04, 0, 0, got);
      check("ro_status", got, 32'hDEAD0001);
      rd(8'h20, 0, 0, got);
      check("oor_read", got, 32'h0);
      wr(8'h08, 32'h7, 4'hF, 0, 0, 0);
      fork
         wr(8'h08, 32'h9, 4'hF, 0, 0, 0);
         begin @(posedge clk); #1; rd(8'h08, 0, 0, got); end
      join
      check("read_during_commit", got, 32'h7);
      rd(8'h08, 0, 0, got);
      check("read_after_commit", got, 32'h9);
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom();
         if ($urandom_range(0, 1) == 1)
            wr(AW'($urandom_range(0, 47)), $urandom(), 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            rd(AW'($urandom_range(0, 47)), $urandom_range(0, 2), $urandom_range(0, 3), got);
      end
      bus0.AWADDR = 8'h0C;
      bus0.AWVALID = 1'b1;
      @(negedge clk);
      check("mid_aw_ready", bus0.AWREADY, 1);
      @(posedge clk);
      #1;
      bus0.AWVALID = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_awready", bus0.AWREADY, 0);
      check("mid_rst_wready", bus0.WREADY, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) mdl[d][i] = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_bvalid", bv[0], 0);
      end
      check("mid_rst_awready_up", bus0.AWREADY, 1);
      check_regs();
      @(posedge clk);
      #1;
      wr(8'h0C, 32'hCAFEF00D, 4'hF, 0, 1, 0);
      rd(8'h0C, 0, 0, got);
      check("post_rst_read", got, 32'hCAFEF00D);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
